// File: rtl/led_blink_arbiter_if.sv
// Request/grant bundle between the LED requesters and led_blink_arbiter.
// master: requester side (drives req, colour, count); slave: the arbiter.
interface led_blink_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) ();
    logic [NUM_REQ-1:0]   req;
    logic [3*NUM_REQ-1:0] req_color;
    logic [4*NUM_REQ-1:0] req_count;
    logic [NUM_REQ-1:0]   gnt;
    logic                 done;
    logic [ID_W-1:0]      done_id;
    logic                 busy;

    modport master (
        output req, req_color, req_count,
        input  gnt, done, done_id, busy
    );

    modport slave (
        input  req, req_color, req_count,
        output gnt, done, done_id, busy
    );
endinterface

// File: rtl/led_blink_arbiter.sv
// led_blink_arbiter: shares the RGB LED between NUM_REQ requesters.
// One requester is granted at a time; its colour blinks req_count times
// (ON and OFF phases of HALF_PERIOD cycles each), completion is pulsed on
// done/done_id, then the LED stays dark for GAP_CYCLES before the next grant.
// Define LED_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the
// lowest-index request wins (fixed priority).
module led_blink_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int CNT_W       = 24,
    parameter int HALF_PERIOD = 4000000,
    parameter int GAP_CYCLES  = 8000000,
    parameter int ID_W        = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    led_blink_arbiter_if.slave bus,
    output logic              redled,
    output logic              greenled,
    output logic              blueled
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_OFF,
        ST_GAP
    } state_t;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PERIOD - 1);
    // A zero-length gap still spends a single cycle in GAP.
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    // Per-requester views of the packed colour/count buses.
    logic [2:0] color_arr [NUM_REQ];
    logic [3:0] count_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign color_arr[gi] = bus.req_color[3*gi +: 3];
            assign count_arr[gi] = bus.req_count[4*gi +: 4];
        end
    endgenerate

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         rem_q, rem_d;
    logic [2:0]         color_q, color_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               done_q, done_d;
    logic [ID_W-1:0]    done_id_q, done_id_d;
    logic               busy_q, busy_d;
    logic [2:0]         led_q, led_d;

    logic               win_valid;
    logic [ID_W-1:0]    win_idx;

`ifdef LED_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0]    ptr_q, ptr_d;
    int                 rr_pos;
    logic [ID_W-1:0]    rr_idx;

    // Round-robin: first asserted request at or after the pointer, wrapping.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        rr_pos    = 0;
        rr_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_pos = int'(ptr_q) + i;
            if (rr_pos >= NUM_REQ) begin
                rr_pos = rr_pos - NUM_REQ;
            end
            rr_idx = ID_W'(rr_pos);
            if (!win_valid && bus.req[rr_idx]) begin
                win_valid = 1'b1;
                win_idx   = rr_idx;
            end
        end
    end
`else
    // Fixed priority: the lowest asserted index wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_valid && bus.req[ID_W'(i)]) begin
                win_valid = 1'b1;
                win_idx   = ID_W'(i);
            end
        end
    end
`endif

    // Next-state logic for the grant / blink / gap sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        color_d   = color_q;
        id_d      = id_q;
        gnt_d     = '0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
`ifdef LED_ARB_ROUND_ROBIN_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    gnt_d[win_idx] = 1'b1;
                    color_d        = color_arr[win_idx];
                    rem_d          = count_arr[win_idx];
                    id_d           = win_idx;
                    cnt_d          = '0;
`ifdef LED_ARB_ROUND_ROBIN_EN
                    ptr_d = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif
                    // A zero-count request completes in its grant cycle.
                    if (count_arr[win_idx] == 4'd0) begin
                        state_d   = ST_GAP;
                        done_d    = 1'b1;
                        done_id_d = win_idx;
                    end else begin
                        state_d = ST_ON;
                    end
                end
            end
            ST_ON: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_OFF;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_OFF: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == 4'd1) begin
                        state_d   = ST_GAP;
                        done_d    = 1'b1;
                        done_id_d = id_q;
                    end else begin
                        state_d = ST_ON;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs follow the next state so they are registered with it.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        led_d  = (state_d == ST_ON) ? color_d : 3'b000;
    end

    // State and output registers; reset drops LEDs and busy immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            color_q   <= '0;
            id_q      <= '0;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            busy_q    <= 1'b0;
            led_q     <= '0;
`ifdef LED_ARB_ROUND_ROBIN_EN
            ptr_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            color_q   <= color_d;
            id_q      <= id_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            busy_q    <= busy_d;
            led_q     <= led_d;
`ifdef LED_ARB_ROUND_ROBIN_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.busy    = busy_q;
    assign redled      = led_q[2];
    assign greenled    = led_q[1];
    assign blueled     = led_q[0];

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Bench for led_blink_arbiter with HALF_PERIOD=4, GAP_CYCLES=2, NUM_REQ=4.
// Expected sequences are pushed to a scoreboard queue as requests are raised;
// a negedge monitor checks grant, LED activity and completion against them.
module tb_led_blink_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int HP      = 4;
    localparam int GAP     = 2;

    typedef struct {
        int         id;
        logic [2:0] color;
        logic [3:0] count;
        logic [3:0] exp_gnt;
        logic [1:0] exp_id;
        int         exp_on;
        int         exp_len;
        int         exp_rise;
    } vec_t;

    logic clk;
    logic rst_n;
    logic redled, greenled, blueled;

    led_blink_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    led_blink_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .CNT_W      (8),
        .HALF_PERIOD(HP),
        .GAP_CYCLES (GAP),
        .ID_W       (ID_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .redled  (redled),
        .greenled(greenled),
        .blueled (blueled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp  = 0;
    int   n_fail = 0;
    vec_t sb_q[$];
    vec_t tbl[5];
    vec_t cur;
    int   cyc = 0;
    int   g_cyc = 0;
    int   d_cyc = -1000;
    int   on_cnt = 0;
    int   rise_cnt = 0;
    int   col_err = 0;
    int   stray_led = 0;
    bit   active = 0;
    logic prev_busy = 1'b0;
    logic [2:0] prev_leds = 3'b000;
    logic [2:0] leds;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                active    = 0;
                d_cyc     = -1000;
                prev_busy = 1'b0;
                prev_leds = 3'b000;
            end else begin
                leds = {redled, greenled, blueled};
                if (bus.gnt != '0) begin
                    check("gnt_after_idle", prev_busy, 0);
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL gnt_unexpected: got %b, required no grant", bus.gnt);
                    end else begin
                        cur = sb_q[0];
                        check("gnt", bus.gnt, cur.exp_gnt);
                        active   = 1;
                        g_cyc    = cyc;
                        on_cnt   = 0;
                        rise_cnt = 0;
                        col_err  = 0;
                    end
                end
                if (active) begin
                    if (leds != 3'b000) begin
                        on_cnt++;
                        if (leds != cur.color) col_err++;
                        if (prev_leds == 3'b000) rise_cnt++;
                    end
                end else if (leds != 3'b000) begin
                    stray_led++;
                end
                if (bus.done) begin
                    if (!active) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL done_unexpected: got done id %0d, required no done", bus.done_id);
                    end else begin
                        check("done_id", bus.done_id, cur.exp_id);
                        check("seq_len", cyc - g_cyc, cur.exp_len);
                        check("led_on_cycles", on_cnt, cur.exp_on);
                        check("blink_count", rise_cnt, cur.exp_rise);
                        check("led_colour_errs", col_err, 0);
                        void'(sb_q.pop_front());
                        active = 0;
                        d_cyc  = cyc;
                    end
                end
                if (cyc == d_cyc + GAP - 1) check("busy_in_gap", bus.busy, 1);
                if (cyc == d_cyc + GAP) begin
                    check("busy_after_gap", bus.busy, 0);
                    $display("txn done: id=%0d at cycle %0d", cur.exp_id, d_cyc);
                end
                prev_busy = bus.busy;
                prev_leds = leds;
            end
        end
    end

    task automatic wait_gnt(input int budget);
        int c;
        c = 0;
        @(negedge clk);
        while (bus.gnt == '0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("gnt_seen", (bus.gnt != '0), 1);
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while ((bus.busy || sb_q.size() != 0) && c < budget);
        check("idle_reached", {bus.busy, (sb_q.size() != 0)}, 0);
        check("stray_led", stray_led, 0);
    endtask

    task automatic set_req(input int id, input logic [2:0] color, input logic [3:0] count);
        bus.req_color[3*id +: 3] = color;
        bus.req_count[4*id +: 4] = count;
    endtask

    initial begin
        int n_rep;
        tbl[0] = '{0, 3'b010, 4'd2,  4'b0001, 2'd0, 8,  16,  2};
        tbl[1] = '{2, 3'b100, 4'd0,  4'b0100, 2'd2, 0,  0,   0};
        tbl[2] = '{3, 3'b111, 4'd15, 4'b1000, 2'd3, 60, 120, 15};
        tbl[3] = '{1, 3'b000, 4'd1,  4'b0010, 2'd1, 0,  8,   0};
        tbl[4] = '{2, 3'b001, 4'd3,  4'b0100, 2'd2, 12, 24,  3};

        rst_n         = 1'b0;
        bus.req       = '0;
        bus.req_color = '0;
        bus.req_count = '0;

        // Two requesters held from reset.
        set_req(1, 3'b011, 4'd1);
        set_req(3, 3'b110, 4'd1);
        bus.req = 4'b1010;
        #12;
        check("rst_gnt", bus.gnt, 0);
        check("rst_done", bus.done, 0);
        check("rst_done_id", bus.done_id, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_leds", {redled, greenled, blueled}, 0);

`ifdef LED_ARB_ROUND_ROBIN_EN
        n_rep = 4;
        sb_q.push_back('{1, 3'b011, 4'd1, 4'b0010, 2'd1, 4, 8, 1});
        sb_q.push_back('{3, 3'b110, 4'd1, 4'b1000, 2'd3, 4, 8, 1});
        sb_q.push_back('{1, 3'b011, 4'd1, 4'b0010, 2'd1, 4, 8, 1});
        sb_q.push_back('{3, 3'b110, 4'd1, 4'b1000, 2'd3, 4, 8, 1});
`else
        n_rep = 3;
        for (int k = 0; k < 3; k++) sb_q.push_back('{1, 3'b011, 4'd1, 4'b0010, 2'd1, 4, 8, 1});
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < n_rep; k++) wait_gnt(200);
        bus.req = '0;
        wait_idle(200);

        // Single-request vectors.
        for (int i = 0; i < 5; i++) begin
            set_req(tbl[i].id, tbl[i].color, tbl[i].count);
            sb_q.push_back(tbl[i]);
            bus.req[tbl[i].id] = 1'b1;
            wait_gnt(50);
            bus.req[tbl[i].id] = 1'b0;
            wait_idle(400);
        end

        // Reset during the second ON phase.
        set_req(0, 3'b001, 4'd3);
        sb_q.push_back('{0, 3'b001, 4'd3, 4'b0001, 2'd0, 12, 24, 3});
        bus.req[0] = 1'b1;
        wait_gnt(50);
        bus.req[0] = 1'b0;
        repeat (9) @(negedge clk);
        check("t4_second_on", blueled, 1);
        #2 rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("t4_rst_leds", {redled, greenled, blueled}, 0);
        check("t4_rst_busy", bus.busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t4_idle_busy", bus.busy, 0);

        // Inputs changed mid-sequence; pointer must restart at 0.
        set_req(0, 3'b010, 4'd2);
        set_req(1, 3'b001, 4'd1);
        set_req(3, 3'b100, 4'd1);
        sb_q.push_back('{0, 3'b010, 4'd2, 4'b0001, 2'd0, 8, 16, 2});
        sb_q.push_back('{1, 3'b001, 4'd1, 4'b0010, 2'd1, 4, 8, 1});
        sb_q.push_back('{3, 3'b100, 4'd1, 4'b1000, 2'd3, 4, 8, 1});
        bus.req = 4'b1001;
        wait_gnt(50);
        bus.req[0] = 1'b0;
        repeat (2) @(negedge clk);
        set_req(0, 3'b101, 4'd7);
        bus.req[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_gnt(100);
            bus.req = bus.req & ~bus.gnt;
        end
        wait_idle(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/led_blink_arbiter.md
Name: led_blink_arbiter

Overview:
- Shares the board RGB LED (redled/greenled/blueled) between NUM_REQ firmware/fabric requesters.
- Each request asks for a colour to blink N times. The block arbitrates, grants one requester at a time, and sequences ON/OFF phases with a cycle counter derived from clk.
- Signals completion per request, then holds a quiet gap before the next grant.
- Sits between the fabric logic clocked by Sys_Clk0 and the LED pads; replaces free-running LED toggles.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CNT_W, 24, phase counter width.
- HALF_PERIOD, 4000000, cycles per ON phase and per OFF phase (1..2^CNT_W-1).
- GAP_CYCLES, 8000000, dark cycles after a request completes (0..2^CNT_W-1).
- ID_W, 2, width of done_id; must equal clog2(NUM_REQ), minimum 1.

Ports:
- clk  in  1  system clock (Sys_Clk0).
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  level request per requester; held until gnt seen.
- req_color  in  3*NUM_REQ  {r,g,b} per requester, slice i = bits [3i+2:3i].
- req_count  in  4*NUM_REQ  blink count per requester, slice i = bits [4i+3:4i].
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse.
- done  out  1  one-cycle completion pulse.
- done_id  out  ID_W  index of the completed requester; valid with done.
- busy  out  1  high in every state except IDLE.
- redled, greenled, blueled  out  1 each  LED drives, active high.

Behaviour:
- Reset (async assert, sync release): state=IDLE; gnt=0, done=0, done_id=0, busy=0, all LEDs 0; phase counter 0; arbitration pointer 0.
- All outputs are registered.
- States: IDLE, ON, OFF, GAP.
- IDLE:
  - If any req bit is high at edge k, select winner w and, for the cycle after edge k:
    - gnt[w]=1 for exactly one cycle;
    - latch color_q=req_color[w], rem_q=req_count[w], id_q=w;
    - counter=0.
  - If rem=0: go to GAP and pulse done (done_id=w) in the grant cycle; LEDs stay dark.
  - If rem>0: go to ON; LEDs=color_q starting in the grant cycle.
- ON:
  - LEDs=color_q; counter increments each cycle.
  - At counter==HALF_PERIOD-1: counter<=0, LEDs<=0, go to OFF. ON lasts exactly HALF_PERIOD cycles.
- OFF:
  - LEDs=0.
  - At counter==HALF_PERIOD-1: counter<=0 and rem_q<=rem_q-1.
    - If rem_q==1: go to GAP and pulse done with done_id=id_q in the next cycle.
    - Otherwise go to ON.
- GAP:
  - LEDs=0; counter counts to GAP_CYCLES-1, then go to IDLE.
  - GAP_CYCLES=0: GAP lasts one cycle.
  - busy drops in the first IDLE cycle.
- Input sampling: req is sampled only in IDLE. req_color and req_count are sampled only at the grant edge; later changes have no effect.
- Repeated requests: a req still high after done is eligible again at the next IDLE.
- Simultaneous requests: resolved by the arbitration scheme (see Optional Feature). Losers keep waiting; no request is dropped.
- Colour 3'b000: sequence still runs (timing, done) with LEDs dark.
- Reset mid-sequence: LEDs and busy go low immediately. The latched request is discarded and no done is generated.

Optional Feature:
- Macro: LED_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - Search starts at the pointer; the winner is the first asserted req at or after the pointer, wrapping.
  - After a grant, pointer<=w+1 (wraps to 0 after NUM_REQ-1).
- Undefined: fixed priority, lowest index wins. Pointer logic is absent.

Test Plan (HALF_PERIOD=4, GAP_CYCLES=2, NUM_REQ=4):
1. req[0]=1, color 3'b010, count 2, deasserted after gnt:
   - gnt=4'b0001 for one cycle;
   - greenled high 4, low 4, high 4, low 4 cycles;
   - done=1 with done_id=0 in the next cycle;
   - busy low 2 cycles later.
2. req[2] with count 0, color 3'b100:
   - gnt[2] pulse and done with done_id=2 in the same cycle;
   - redled never high;
   - back to IDLE after 2 GAP cycles.
3. req[1] and req[3] high simultaneously from reset, both held:
   - Round-robin: grants 1, 3, 1, 3.
   - Fixed priority: grants 1, 1, 1.
   - Each grant is followed by a full sequence and gap.
4. req[0] count 3, rst_n pulled low during the second ON phase:
   - All LEDs 0 and busy 0 within the reset assertion, with no clock edge needed;
   - no done;
   - after release, IDLE with pointer 0.
5. During ON, change req_color[0] and req_count[0] and assert req[1]:
   - LED colour and blink count are unchanged;
   - gnt[1] only after GAP completes.
6. req[3] count 15, color 3'b111:
   - All three LEDs blink 15 times (120 cycles of ON/OFF);
   - rem wraps correctly;
   - single done with done_id=3.
